// File: rtl/nibble_serial_tx_pkg.sv
// Shared types and constants for the nibble serial transmitter.
// Define NIBBLE_TX_PARITY_EN to add an even-parity bit between data and stop.
package nibble_tx_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam int   DATA_BITS = 4;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

`ifdef NIBBLE_TX_PARITY_EN
  localparam int FRAME_BITS = DATA_BITS + 3;
`else
  localparam int FRAME_BITS = DATA_BITS + 2;
`endif

  function automatic logic even_parity(input logic [DATA_BITS-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/nibble_serial_tx_if.sv
// Producer-side handshake plus serial line status for nibble_serial_tx.
interface nibble_serial_tx_if;

  logic [nibble_tx_pkg::DATA_BITS-1:0] din;
  logic                                din_valid;
  logic                                din_ready;
  logic                                tx;
  logic                                busy;
  logic                                done;

  modport master (
    output din, din_valid,
    input  din_ready, tx, busy, done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, tx, busy, done
  );

endinterface

// File: rtl/nibble_serial_tx_bit_timer.sv
// Bit-period divider: tick pulses on the last clk of each serial bit while run is high.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  assign tick = run && (cnt_reg == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    cnt_next = cnt_reg + CNT_W'(1);
    if (!run || tick) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/nibble_serial_tx.sv
// Framed serial transmitter: start bit, 4 data bits LSB first, stop bit.
// Optional even-parity bit before stop when NIBBLE_TX_PARITY_EN is defined.
module nibble_serial_tx
  import nibble_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  nibble_serial_tx_if.slave   bus
);

  localparam int BCNT_W = $clog2(DATA_BITS);

  tx_state_t              state_reg, state_next;
  logic [DATA_BITS-1:0]   shreg_reg, shreg_next;
  logic [BCNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
  logic                   tx_reg, tx_next;
  logic                   done_reg, done_next;
  logic                   tick;
  logic                   accept;

  bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (state_reg != IDLE),
    .tick  (tick)
  );

  assign accept        = bus.din_valid && (state_reg == IDLE);
  assign bus.din_ready = (state_reg == IDLE);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.tx        = tx_reg;
  assign bus.done      = done_reg;

`ifdef NIBBLE_TX_PARITY_EN
  logic parity_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_reg <= 1'b0;
    end else if (accept) begin
      parity_reg <= even_parity(bus.din);
    end
  end
`endif

  always_comb begin
    state_next   = state_reg;
    shreg_next   = shreg_reg;
    bit_cnt_next = bit_cnt_reg;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = START;
          shreg_next = bus.din;
        end
      end
      START: begin
        if (tick) begin
          state_next   = DATA;
          bit_cnt_next = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shreg_next   = shreg_reg >> 1;
          bit_cnt_next = bit_cnt_reg + BCNT_W'(1);
          if (bit_cnt_reg == BCNT_W'(DATA_BITS - 1)) begin
`ifdef NIBBLE_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef NIBBLE_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // tx is driven from the upcoming state so the line changes exactly on the bit boundary.
  always_comb begin
    tx_next = IDLE_LVL;
    case (state_next)
      START:  tx_next = START_LVL;
      DATA:   tx_next = shreg_next[0];
`ifdef NIBBLE_TX_PARITY_EN
      PARITY: tx_next = parity_reg;
`endif
      STOP:   tx_next = STOP_LVL;
      default: tx_next = IDLE_LVL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      shreg_reg   <= '0;
      bit_cnt_reg <= '0;
      tx_reg      <= IDLE_LVL;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shreg_reg   <= shreg_next;
      bit_cnt_reg <= bit_cnt_next;
      tx_reg      <= tx_next;
      done_reg    <= done_next;
    end
  end

endmodule

// File: tb/tb_nibble_serial_tx.sv
// Scoreboard bench for nibble_serial_tx: stimulus queues accepted words, a monitor checks each frame.
module tb_nibble_serial_tx;
  import nibble_tx_pkg::*;

  localparam int CPB = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   n_frames;
  int   n_aborted;
  logic [3:0] exp_q[$];

  nibble_serial_tx_if bus_if ();

  nibble_serial_tx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Waits for a negedge with din_ready, presents the word and lets the next posedge take it.
  task automatic send(input logic [3:0] w, input bit hold);
    int waited = 0;
    @(negedge clk);
    while (bus_if.din_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("send_ready_timeout", 32'(waited < 200), 32'd1);
    bus_if.din       = w;
    bus_if.din_valid = 1'b1;
    exp_q.push_back(w);
    $display("stim: word %h offered", w);
    @(posedge clk);
    #1;
    if (!hold) bus_if.din_valid = 1'b0;
  endtask

  task automatic wait_done();
    int waited = 0;
    @(negedge clk);
    while (bus_if.done !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("done_timeout", 32'(waited < 200), 32'd1);
  endtask

  initial begin : monitor
    logic       prev_busy;
    logic [3:0] w;
    logic       bits   [0:7];
    logic       bit_act[0:7];
    logic       aborted, busy_bad, rdy_bad, done_bad;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus_if.busy === 1'b1 && !prev_busy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
        end else begin
          w = exp_q.pop_front();
          for (int i = 0; i < 8; i++) bits[i] = 1'b1;
          bits[0] = 1'b0;
          for (int i = 0; i < 4; i++) bits[1+i] = w[i];
`ifdef NIBBLE_TX_PARITY_EN
          bits[5] = ^w;
`endif
          aborted = 1'b0; busy_bad = 1'b0; rdy_bad = 1'b0; done_bad = 1'b0;
          for (int b = 0; b < FRAME_BITS && !aborted; b++) begin
            bit_act[b] = bits[b];
            for (int c = 0; c < CPB && !aborted; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (rst_n !== 1'b1) begin
                aborted = 1'b1;
              end else begin
                if (bus_if.tx !== bits[b]) bit_act[b] = bus_if.tx;
                if (bus_if.busy !== 1'b1) busy_bad = 1'b1;
                if (bus_if.din_ready !== 1'b0) rdy_bad = 1'b1;
                if (bus_if.done !== 1'b0) done_bad = 1'b1;
              end
            end
          end
          if (aborted) begin
            n_aborted++;
            $display("mon: frame for word %h aborted by reset", w);
          end else begin
            for (int b = 0; b < FRAME_BITS; b++)
              check($sformatf("frame%0d_bit%0d", n_frames, b), 32'(bit_act[b]), 32'(bits[b]));
            check($sformatf("frame%0d_busy_held", n_frames), 32'(busy_bad), 32'd0);
            check($sformatf("frame%0d_ready_low", n_frames), 32'(rdy_bad), 32'd0);
            check($sformatf("frame%0d_no_early_done", n_frames), 32'(done_bad), 32'd0);
            @(negedge clk);
            check($sformatf("frame%0d_done_pulse", n_frames), 32'(bus_if.done), 32'd1);
            check($sformatf("frame%0d_idle_after", n_frames),
                  {29'd0, bus_if.busy, bus_if.tx, bus_if.din_ready}, 32'b011);
            $display("mon: frame %0d word %h checked", n_frames, w);
            n_frames++;
          end
        end
      end
      prev_busy = (rst_n === 1'b1) ? bus_if.busy : 1'b0;
    end
  end

  initial begin : stimulus
    int waited;
    n_checks = 0; n_pass = 0; n_frames = 0; n_aborted = 0;
    rst_n            = 1'b1;
    bus_if.din       = 4'h9;
    bus_if.din_valid = 1'b1;
    #1 rst_n = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset_outputs_c%0d", i),
            {28'd0, bus_if.tx, bus_if.din_ready, bus_if.busy, bus_if.done}, 32'b1100);
    end
    bus_if.din_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_no_accept", 32'(bus_if.busy), 32'd0);

    // single frame, 1011 -> 0,1,1,0,1,1
    send(4'b1011, 1'b0);

    // back-to-back with din_valid held, then din changed to F while busy
    send(4'hA, 1'b1);
    wait_done();
    bus_if.din = 4'h5;
    exp_q.push_back(4'h5);
    $display("stim: word 5 offered on done cycle");
    @(posedge clk);
    repeat (6) @(posedge clk);
    #1 bus_if.din = 4'hF;
    wait_done();
    bus_if.din_valid = 1'b0;

    // reset during data bit 2
    send(4'h6, 1'b0);
    repeat (12) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_tx_high", 32'(bus_if.tx), 32'd1);
    check("async_reset_busy_low", 32'(bus_if.busy), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("after_abort_idle",
          {29'd0, bus_if.tx, bus_if.din_ready, bus_if.busy}, 32'b110);
    send(4'h3, 1'b0);

    waited = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || bus_if.busy !== 1'b0) && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    repeat (3) @(negedge clk);
    check("drain_timeout", 32'(waited < 500), 32'd1);
    check("frames_completed", 32'(n_frames), 32'd4);
    check("frames_aborted", 32'(n_aborted), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
